aes_round_sequencer: RTL and testbench

Iterative AES block controller. It accepts one 128-bit block through a valid/ready handshake and applies the initial AddRoundKey. It then steps an external single-round datapath NUM_ROUNDS times while driving the round index to the key-schedule store, and presents the ciphertext on a valid/ready output port. It sits between the input block FIFO and the round-function/key-schedule logic, and owns the round count internally.

---
 rtl/aes_round_sequencer.sv | 123 ++++++++++++
 tb/tb_aes_round_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Iterative AES block controller: takes one block, applies the whitening key,
// steps an external single-round datapath NUM_ROUNDS times and holds the result.
module aes_round_sequencer #(
  parameter int NUM_ROUNDS = 10,
  parameter int DATA_W     = 128
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [3:0]        round_idx,
  input  logic [DATA_W-1:0] round_key,
  output logic [DATA_W-1:0] rf_state,
  output logic              rf_final,
  input  logic [DATA_W-1:0] rf_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy
);

  if ((NUM_ROUNDS < 1) || (NUM_ROUNDS > 15)) begin : g_bad_rounds
    $error("aes_round_sequencer: NUM_ROUNDS must lie within 1..15");
  end

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_HOLD  = 2'd2
  } fsm_e;

  fsm_e              fsm_q, fsm_d;
  logic [3:0]        idx_q, idx_d;
  logic [DATA_W-1:0] blk_q, blk_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;
  logic              rf_final_q, rf_final_d;

  assign in_ready  = (fsm_q == ST_IDLE);
  assign round_idx = idx_q;
  assign rf_state  = blk_q;
  assign out_data  = blk_q;
  assign rf_final  = rf_final_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

  // Next-state, next-index and next-block computation.
  always_comb begin
    fsm_d = fsm_q;
    idx_d = idx_q;
    blk_d = blk_q;
    if (idx_q > LAST_IDX) begin
      // Unreachable index: abandon whatever was in flight.
      fsm_d = ST_IDLE;
      idx_d = 4'd0;
    end else begin
      case (fsm_q)
        ST_IDLE: begin
          idx_d = 4'd0;
          if (in_valid && in_ready) begin
            blk_d = in_data ^ round_key;
            idx_d = 4'd1;
            fsm_d = ST_ROUND;
          end else begin
            fsm_d = ST_IDLE;
          end
        end
        ST_ROUND: begin
          if (idx_q == 4'd0) begin
            fsm_d = ST_IDLE;
            idx_d = 4'd0;
          end else if (idx_q == LAST_IDX) begin
            blk_d = rf_result;
            idx_d = 4'd0;
            fsm_d = ST_HOLD;
          end else begin
            blk_d = rf_result;
            idx_d = idx_q + 4'd1;
          end
        end
        ST_HOLD: begin
          idx_d = 4'd0;
          if (out_ready) begin
            fsm_d = ST_IDLE;
          end else begin
            fsm_d = ST_HOLD;
          end
        end
        default: begin
          fsm_d = ST_IDLE;
          idx_d = 4'd0;
        end
      endcase
    end
    // Status outputs are decoded from the next state so they leave a flop.
    out_valid_d = (fsm_d == ST_HOLD);
    busy_d      = (fsm_d == ST_ROUND) || (fsm_d == ST_HOLD);
    rf_final_d  = (fsm_d == ST_ROUND) && (idx_d == LAST_IDX);
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm_q       <= ST_IDLE;
      idx_q       <= 4'd0;
      blk_q       <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      rf_final_q  <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      idx_q       <= idx_d;
      blk_q       <= blk_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      rf_final_q  <= rf_final_d;
    end
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: AES round function and key store modelled here,
// one instance with 10 rounds and one with 14 rounds.
module tb_aes_round_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset, in_valid, out_ready, sel;
  logic [127:0] in_data;

  logic         in_valid_a, in_ready_a, rf_final_a, out_valid_a, busy_a;
  logic [3:0]   round_idx_a;
  logic [127:0] round_key_a, rf_state_a, rf_result_a, out_data_a;
  logic         in_valid_b, in_ready_b, rf_final_b, out_valid_b, busy_b;
  logic [3:0]   round_idx_b;
  logic [127:0] round_key_b, rf_state_b, rf_result_b, out_data_b;

  logic [127:0] rk_a [16];
  logic [127:0] rk_b [16];

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- AES reference arithmetic ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r, s, b;
    r = 8'h01; s = x;
    for (int k = 1; k < 8; k++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] t);
    return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic fin);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = sbox(st[127-8*i -: 8]);
    for (int i = 0; i < 16; i++) t[i] = s[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
      if (fin) begin
        o[127-32*c -: 32] = {a0, a1, a2, a3};
      end else begin
        o[127-32*c -: 32] = {gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3,
                             a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3,
                             a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3),
                             gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3)};
      end
    end
    return o ^ rk;
  endfunction

  // Key left-justified in 256 bits; nk = key length in 32-bit words.
  function automatic logic [127:0] key_sched(input logic [255:0] key, input int nk, input int r);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < 4 * (r + 1); i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
          rc = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          t = subword(t);
        end
        w[i] = w[i-nk] ^ t;
      end
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  function automatic logic [127:0] aes_encrypt(input logic [127:0] pt, input logic [255:0] key,
                                               input int nk, input int nr);
    logic [127:0] s;
    s = pt ^ key_sched(key, nk, 0);
    for (int r = 1; r <= nr; r++) s = aes_round(s, key_sched(key, nk, r), (r == nr));
    return s;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- external datapath models ----------------
  assign in_valid_a  = in_valid & ~sel;
  assign in_valid_b  = in_valid & sel;
  assign round_key_a = rk_a[round_idx_a];
  assign round_key_b = rk_b[round_idx_b];
  always_comb rf_result_a = aes_round(rf_state_a, round_key_a, rf_final_a);
  always_comb rf_result_b = aes_round(rf_state_b, round_key_b, rf_final_b);

  aes_round_sequencer #(.NUM_ROUNDS(10), .DATA_W(128)) dut_a (
    .clock(clock), .reset(reset),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data),
    .round_idx(round_idx_a), .round_key(round_key_a),
    .rf_state(rf_state_a), .rf_final(rf_final_a), .rf_result(rf_result_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a), .busy(busy_a)
  );

  aes_round_sequencer #(.NUM_ROUNDS(14), .DATA_W(128)) dut_b (
    .clock(clock), .reset(reset),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data),
    .round_idx(round_idx_b), .round_key(round_key_b),
    .rf_state(rf_state_b), .rf_final(rf_final_b), .rf_result(rf_result_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b), .busy(busy_b)
  );

  logic         v_in_ready, v_out_valid, v_busy, v_rf_final;
  logic [3:0]   v_round_idx;
  logic [127:0] v_out_data, v_rf_state;
  assign v_in_ready  = sel ? in_ready_b  : in_ready_a;
  assign v_out_valid = sel ? out_valid_b : out_valid_a;
  assign v_busy      = sel ? busy_b      : busy_a;
  assign v_rf_final  = sel ? rf_final_b  : rf_final_a;
  assign v_round_idx = sel ? round_idx_b : round_idx_a;
  assign v_out_data  = sel ? out_data_b  : out_data_a;
  assign v_rf_state  = sel ? rf_state_b  : rf_state_a;

  // ---------------- checking helpers ----------------
  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_key(input logic which, input logic [255:0] key);
    for (int r = 0; r < 16; r++) begin
      if (which) rk_b[r] = (r <= 14) ? key_sched(key, 8, r) : 128'h0;
      else       rk_a[r] = (r <= 10) ? key_sched(key, 4, r) : 128'h0;
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_int({tag, " out_valid"}, int'(v_out_valid), 0);
    check_int({tag, " in_ready"},  int'(v_in_ready), 1);
    check_int({tag, " busy"},      int'(v_busy), 0);
    check_int({tag, " round_idx"}, int'(v_round_idx), 0);
    check_int({tag, " rf_final"},  int'(v_rf_final), 0);
  endtask

  // One block through the selected instance, with 'hold' cycles of backpressure.
  task automatic run_block(input string tag, input logic [127:0] pt, input logic [127:0] exp,
                           input int nr, input int hold);
    bit           ok;
    int           e, w;
    logic [127:0] held;
    w = 0;
    while (!v_in_ready && w < 50) begin step(); w++; end
    check_int({tag, " ready before accept"}, int'(v_in_ready), 1);
    check_int({tag, " idx before accept"}, int'(v_round_idx), 0);
    in_valid = 1'b1;
    in_data  = pt;
    step();
    in_valid = 1'b0;
    in_data  = rand128();
    ok = 1'b1;
    e  = 1;
    while (!v_out_valid && e <= nr + 3) begin
      if (int'(v_round_idx) != e || v_rf_final != (e == nr) || !v_busy || v_in_ready) ok = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      in_data   = rand128();
      step();
      e++;
    end
    out_ready = 1'b0;
    check_int({tag, " round sequence"}, int'(ok), 1);
    check_int({tag, " edges to out_valid incl accept"}, e, nr + 1);
    check_val({tag, " out_data"}, v_out_data, exp);
    check_int({tag, " hold idx"}, int'(v_round_idx), 0);
    check_int({tag, " hold rf_final"}, int'(v_rf_final), 0);
    held = v_out_data;
    ok   = 1'b1;
    for (int h = 0; h < hold; h++) begin
      step();
      if (!v_out_valid || v_out_data !== held || v_in_ready || !v_busy) ok = 1'b0;
    end
    if (hold > 0) check_int({tag, " backpressure hold"}, int'(ok), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_int({tag, " out_valid after take"}, int'(v_out_valid), 0);
    check_int({tag, " in_ready after take"}, int'(v_in_ready), 1);
    check_int({tag, " busy after take"}, int'(v_busy), 0);
  endtask

  task automatic back_to_back();
    logic [127:0] blk [3];
    logic [127:0] expq [$];
    int           acc_t [$];
    logic [255:0] key;
    int           nacc, ndel, t;
    bit           acc, del;
    key = {rand128(), 128'h0};
    load_key(1'b0, key);
    for (int i = 0; i < 3; i++) begin
      blk[i] = rand128();
      expq.push_back(aes_encrypt(blk[i], key, 4, 10));
    end
    nacc = 0; ndel = 0; t = 0;
    in_valid = 1'b1; in_data = blk[0]; out_ready = 1'b1;
    while (ndel < 3 && t < 100) begin
      acc = in_valid && v_in_ready;
      del = v_out_valid && out_ready;
      if (del) begin
        check_val($sformatf("b2b out %0d", ndel), v_out_data, expq.pop_front());
        ndel++;
      end
      step();
      t++;
      if (acc) begin
        acc_t.push_back(t);
        nacc++;
        if (nacc < 3) in_data = blk[nacc];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check_int("b2b deliveries", ndel, 3);
    check_int("b2b accepts", nacc, 3);
    if (acc_t.size() == 3) begin
      check_int("b2b accept gap 1", acc_t[1] - acc_t[0], 12);
      check_int("b2b accept gap 2", acc_t[2] - acc_t[1], 12);
    end
  endtask

  typedef struct packed {
    logic         use_b;
    logic [255:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    logic [7:0]   hold;
  } vec_t;

  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    vec_t         vecs [4];
    bit           ok;
    int           w;
    logic [255:0] key;
    logic [127:0] pt;

    vecs[0] = '{1'b0, {C1_KEY, 128'h0}, C1_PT, C1_CT, 8'd0};
    vecs[1] = '{1'b0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3243f6a8885a308d313198a2e0370734,
                128'h3925841d02dc09fbdc118597196a0b32, 8'd3};
    vecs[2] = '{1'b0, {C1_KEY, 128'h0}, C1_PT, C1_CT, 8'd20};
    vecs[3] = '{1'b1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                C1_PT, 128'h8ea2b7ca516745bfeafc49904b496089, 8'd0};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 128'h0; sel = 1'b0;
    load_key(1'b0, vecs[0].key);
    load_key(1'b1, vecs[3].key);
    repeat (3) @(posedge clock);
    #1;
    check_idle("reset A");
    check_val("reset A state", v_rf_state, 128'h0);
    check_val("reset A out_data", v_out_data, 128'h0);
    sel = 1'b1;
    #1;
    check_idle("reset B");
    check_val("reset B state", v_rf_state, 128'h0);
    sel = 1'b0;
    #1;
    reset = 1'b0;

    for (int v = 0; v < 4; v++) begin
      sel = vecs[v].use_b;
      load_key(vecs[v].use_b, vecs[v].key);
      #1;
      run_block($sformatf("vec%0d", v), vecs[v].pt, vecs[v].ct,
                vecs[v].use_b ? 14 : 10, int'(vecs[v].hold));
    end

    // Random blocks and keys on both instances against the reference encryptor.
    for (int k = 0; k < 4; k++) begin
      sel = k[0];
      pt  = rand128();
      key = sel ? {rand128(), rand128()} : {rand128(), 128'h0};
      load_key(sel, key);
      #1;
      run_block($sformatf("rand%0d", k), pt, aes_encrypt(pt, key, sel ? 8 : 4, sel ? 14 : 10),
                sel ? 14 : 10, $urandom_range(0, 4));
    end

    sel = 1'b0;
    #1;
    back_to_back();

    // Reset while round_idx is 5: the block must vanish.
    load_key(1'b0, vecs[0].key);
    w = 0;
    while (!v_in_ready && w < 50) begin step(); w++; end
    in_valid = 1'b1; in_data = C1_PT;
    step();
    in_valid = 1'b0;
    w = 0;
    while (v_round_idx != 4'd5 && w < 20) begin step(); w++; end
    check_int("abort reached idx 5", int'(v_round_idx), 5);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("after abort");
    ok = 1'b1;
    repeat (15) begin
      step();
      if (v_out_valid || v_busy) ok = 1'b0;
    end
    check_int("abort no output", int'(ok), 1);
    run_block("after abort", C1_PT, C1_CT, 10, 0);

    // Reset and in_valid on the same edge: nothing accepted.
    in_valid = 1'b1; in_data = C1_PT; reset = 1'b1;
    step();
    reset = 1'b0; in_valid = 1'b0;
    check_idle("reset+valid");
    ok = 1'b1;
    repeat (15) begin
      step();
      if (v_out_valid || v_busy) ok = 1'b0;
    end
    check_int("reset+valid stays idle", int'(ok), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got time limit reached, expected bench to finish");
    $fatal(1, "bench time limit reached");
  end

endmodule
